// File: rtl/alu_instr_encoder.sv
// Encodes an abstract ALU operation request into an RV32I R-type/I-type instruction
// word and queues it in a small FIFO with valid/ready handshakes on both sides.
module alu_instr_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic             in_itype,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [11:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [1:0]       out_alu_op,
  output logic             err_illegal,
  output logic [CNT_W-1:0] issued_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_XOR = 4'b1100
  } alu_op_e;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;

  logic [31:0]      mem_instr [DEPTH];
  logic [1:0]       mem_alu_op [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;

  logic             enc_legal;
  logic [2:0]       enc_funct3;
  logic [6:0]       enc_funct7;
  logic [31:0]      enc_instr;
  logic [1:0]       enc_alu_op;

  logic             accept;
  logic             push;
  logic             pop;
  logic [OCC_W-1:0] next_occ;
  logic [PTR_W-1:0] next_rd_ptr;
  logic [31:0]      next_head_instr;
  logic [1:0]       next_head_alu_op;

  // Field selection mirrors the ALU controller decode; SUBI has no encoding.
  always_comb begin
    enc_legal  = 1'b1;
    enc_funct3 = 3'b000;
    enc_funct7 = 7'b0000000;
    case (in_op)
      OP_AND: enc_funct3 = 3'b111;
      OP_OR:  enc_funct3 = 3'b110;
      OP_XOR: enc_funct3 = 3'b100;
      OP_SLT: enc_funct3 = 3'b010;
      OP_ADD: enc_funct3 = 3'b000;
      OP_SUB: begin
        enc_funct3 = 3'b000;
        enc_funct7 = 7'b0100000;
        if (in_itype) enc_legal = 1'b0;
      end
      default: enc_legal = 1'b0;
    endcase
    if (in_itype) begin
      enc_instr  = {in_imm, in_rs1, enc_funct3, in_rd, OPC_ITYPE};
      enc_alu_op = 2'b00;
    end else begin
      enc_instr  = {enc_funct7, in_rs2, in_rs1, enc_funct3, in_rd, OPC_RTYPE};
      enc_alu_op = 2'b10;
    end
  end

  assign accept      = in_valid && in_ready;
  assign push        = accept && enc_legal;
  assign pop         = out_valid && out_ready;
  assign next_occ    = occ + OCC_W'(push) - OCC_W'(pop);
  assign next_rd_ptr = rd_ptr + PTR_W'(pop);

  // When the head slot after this edge is the one being written now, bypass the
  // storage so an empty FIFO presents the new request one cycle after acceptance.
  always_comb begin
    if (push && (next_rd_ptr == wr_ptr)) begin
      next_head_instr  = enc_instr;
      next_head_alu_op = enc_alu_op;
    end else begin
      next_head_instr  = mem_instr[next_rd_ptr];
      next_head_alu_op = mem_alu_op[next_rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr]  <= enc_instr;
      mem_alu_op[wr_ptr] <= enc_alu_op;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_alu_op  <= '0;
      err_illegal <= 1'b0;
      issued_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr      <= next_rd_ptr;
      occ         <= next_occ;
      in_ready    <= (next_occ != FULL_OCC);
      out_valid   <= (next_occ != '0);
      err_illegal <= accept && !enc_legal;
      if (next_occ != '0) begin
        out_instr  <= next_head_instr;
        out_alu_op <= next_head_alu_op;
      end
      if (pop) issued_cnt <= issued_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_instr_encoder.sv
// Directed bench for alu_instr_encoder: a reference encoder feeds a scoreboard queue
// that is compared against the DUT output head every cycle.
module tb_alu_instr_encoder;

  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  localparam logic [3:0] AND_OP = 4'b0000;
  localparam logic [3:0] OR_OP  = 4'b0001;
  localparam logic [3:0] ADD_OP = 4'b0010;
  localparam logic [3:0] SUB_OP = 4'b0110;
  localparam logic [3:0] SLT_OP = 4'b0111;
  localparam logic [3:0] XOR_OP = 4'b1100;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic             in_itype;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [11:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [1:0]       out_alu_op;
  logic             err_illegal;
  logic [CNT_W-1:0] issued_cnt;

  typedef struct {
    logic        legal;
    logic [31:0] instr;
    logic [1:0]  alu_op;
  } exp_t;

  exp_t             sb_q[$];
  logic [CNT_W-1:0] cnt_m;
  logic             err_m;
  logic             last_acc;
  int               n_checks;
  int               n_fail;

  alu_instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_itype(in_itype),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_alu_op(out_alu_op),
    .err_illegal(err_illegal), .issued_cnt(issued_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t modelEncode(logic [3:0] op, logic itype, logic [4:0] rd,
                                       logic [4:0] rs1, logic [4:0] rs2, logic [11:0] imm);
    exp_t       e;
    logic [2:0] f3;
    logic [6:0] f7;
    e.legal = 1'b1;
    f7 = 7'd0;
    f3 = 3'd0;
    if (op == AND_OP)      f3 = 3'b111;
    else if (op == OR_OP)  f3 = 3'b110;
    else if (op == XOR_OP) f3 = 3'b100;
    else if (op == SLT_OP) f3 = 3'b010;
    else if (op == ADD_OP) f3 = 3'b000;
    else if (op == SUB_OP) begin
      f7 = 7'b0100000;
      if (itype) e.legal = 1'b0;
    end else e.legal = 1'b0;
    if (itype) begin
      e.instr  = {imm, rs1, f3, rd, 7'b0010011};
      e.alu_op = 2'b00;
    end else begin
      e.instr  = {f7, rs2, rs1, f3, rd, 7'b0110011};
      e.alu_op = 2'b10;
    end
    return e;
  endfunction

  task automatic checkEq(string tag, logic [31:0] observed, logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    checkEq("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
    checkEq("in_ready", 32'(in_ready), 32'(sb_q.size() < DEPTH));
    checkEq("err_illegal", 32'(err_illegal), 32'(err_m));
    checkEq("issued_cnt", 32'(issued_cnt), 32'(cnt_m));
    if (sb_q.size() != 0) begin
      checkEq("out_instr", out_instr, sb_q[0].instr);
      checkEq("out_alu_op", 32'(out_alu_op), 32'(sb_q[0].alu_op));
    end
  endtask

  task automatic applyStimulus(logic v, logic [3:0] op, logic itype, logic [4:0] rd,
                               logic [4:0] rs1, logic [4:0] rs2, logic [11:0] imm);
    in_valid = v;
    in_op    = op;
    in_itype = itype;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
  endtask

  // One clock: update the model from the inputs in force, then compare after the edge.
  task automatic step();
    logic pop_m;
    logic acc_m;
    exp_t e;
    pop_m = (sb_q.size() != 0) && out_ready;
    acc_m = in_valid && (sb_q.size() < DEPTH);
    e = modelEncode(in_op, in_itype, in_rd, in_rs1, in_rs2, in_imm);
    if (pop_m) begin
      void'(sb_q.pop_front());
      cnt_m = cnt_m + 1'b1;
    end
    if (acc_m && e.legal) sb_q.push_back(e);
    err_m = acc_m && !e.legal;
    @(posedge clk);
    #1;
    last_acc = acc_m;
    checkOutput();
  endtask

  task automatic sendReq(logic [3:0] op, logic itype, logic [4:0] rd,
                         logic [4:0] rs1, logic [4:0] rs2, logic [11:0] imm);
    bit done;
    done = 0;
    applyStimulus(1'b1, op, itype, rd, rs1, rs2, imm);
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      if (last_acc) done = 1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $error("[TB] FAIL accept_timeout observed=not_accepted expected=accepted");
    end
    applyStimulus(1'b0, 4'd0, 1'b0, 5'd0, 5'd0, 5'd0, 12'd0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb_q.delete();
    cnt_m = '0;
    err_m = 1'b0;
    checkOutput();
    checkEq("rst_out_instr", out_instr, 32'h0);
    checkEq("rst_out_alu_op", 32'(out_alu_op), 32'h0);
  endtask

  initial begin
    bit drained;
    n_checks = 0;
    n_fail   = 0;
    cnt_m    = '0;
    err_m    = 1'b0;
    last_acc = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 4'd0, 1'b0, 5'd0, 5'd0, 5'd0, 12'd0);
    doReset();

    // R ADD, single entry through an empty FIFO
    sendReq(ADD_OP, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0);
    checkEq("add_instr", out_instr, 32'h003100B3);
    checkEq("add_alu_op", 32'(out_alu_op), 32'h2);
    step();
    checkEq("add_issued", 32'(issued_cnt), 32'd1);

    // SUB then SLT back to back, no bubble
    sendReq(SUB_OP, 1'b0, 5'd5, 5'd6, 5'd7, 12'd0);
    checkEq("sub_instr", out_instr, 32'h407302B3);
    sendReq(SLT_OP, 1'b0, 5'd10, 5'd11, 5'd12, 12'd0);
    checkEq("slt_instr", out_instr, 32'h00C5A533);
    checkEq("slt_valid", 32'(out_valid), 32'h1);
    step();

    // I XOR, then the illegal SUBI form
    sendReq(XOR_OP, 1'b1, 5'd1, 5'd1, 5'd0, 12'hFFF);
    checkEq("xori_instr", out_instr, 32'hFFF0C093);
    checkEq("xori_alu_op", 32'(out_alu_op), 32'h0);
    step();
    sendReq(SUB_OP, 1'b1, 5'd1, 5'd1, 5'd0, 12'hFFF);
    checkEq("subi_err", 32'(err_illegal), 32'h1);
    checkEq("subi_cnt", 32'(issued_cnt), 32'd4);
    step();
    checkEq("subi_err_clear", 32'(err_illegal), 32'h0);

    // Backpressure: fill, hold, then drain in order
    out_ready = 1'b0;
    sendReq(AND_OP, 1'b0, 5'd3, 5'd4, 5'd5, 12'd0);
    sendReq(OR_OP, 1'b1, 5'd6, 5'd7, 5'd0, 12'h123);
    checkEq("full_in_ready", 32'(in_ready), 32'h0);
    applyStimulus(1'b1, ADD_OP, 1'b1, 5'd8, 5'd9, 5'd0, 12'h7FF);
    repeat (3) step();
    checkEq("and_held", out_instr, 32'h005271B3);
    out_ready = 1'b1;
    sendReq(ADD_OP, 1'b1, 5'd8, 5'd9, 5'd0, 12'h7FF);
    drained = 0;
    for (int i = 0; i < 10 && !drained; i++) begin
      step();
      if (sb_q.size() == 0) drained = 1;
    end
    checkEq("drain_done", 32'(drained), 32'h1);
    checkEq("drain_cnt", 32'(issued_cnt), 32'd7);

    // Illegal opcode, back-to-back pulses, then a legal ADD
    applyStimulus(1'b1, 4'b1111, 1'b0, 5'd1, 5'd1, 5'd1, 12'd0);
    step();
    checkEq("ill_pulse1", 32'(err_illegal), 32'h1);
    step();
    checkEq("ill_pulse2", 32'(err_illegal), 32'h1);
    sendReq(ADD_OP, 1'b0, 5'd31, 5'd30, 5'd29, 12'd0);
    checkEq("post_ill_err", 32'(err_illegal), 32'h0);
    checkEq("post_ill_instr", out_instr, 32'h01DF0FB3);
    step();

    // Reset with two queued entries discards them
    out_ready = 1'b0;
    sendReq(XOR_OP, 1'b0, 5'd2, 5'd3, 5'd4, 12'd0);
    sendReq(SLT_OP, 1'b1, 5'd2, 5'd3, 5'd0, 12'h800);
    doReset();
    out_ready = 1'b1;
    repeat (3) step();
    checkEq("post_rst_valid", 32'(out_valid), 32'h0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
